// File: rtl/inst_mem_server.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_server
// Purpose  : Instruction memory with a fixed-latency read pipeline, an
//            in-order response FIFO, credit-based request throttling,
//            flush (branch cancel) and a side write port for loading code.
// Revision : 1.0 - initial release
// ============================================================================
module inst_mem_server #(
    parameter int DEPTH       = 64,
    parameter int LATENCY     = 2,
    parameter int OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_addr,
    output logic [31:0] resp_inst,
    output logic        resp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        busy
);

    localparam int          c_aw      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          c_pw      = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int          c_cw      = $clog2(OUTSTANDING + 1);
    localparam logic [29:0] c_depth_w = 30'(DEPTH);

    logic [31:0]     mem_q [DEPTH];

    logic            w_acc;
    logic            w_rd_err;
    logic [31:0]     w_rd_data;
    logic            w_push_v;
    logic [31:0]     w_push_addr;
    logic [31:0]     w_push_data;
    logic            w_push_err;
    logic            w_push;
    logic            w_pop;

    logic [31:0]     fa_q [OUTSTANDING];
    logic [31:0]     fd_q [OUTSTANDING];
    logic            fe_q [OUTSTANDING];
    logic [c_pw-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_pw-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cw-1:0] fcnt_q, fcnt_d;
    logic [c_cw-1:0] cnt_q, cnt_d;

    function automatic logic [c_pw-1:0] ptr_inc(input logic [c_pw-1:0] p);
        return (p == c_pw'(OUTSTANDING - 1)) ? '0 : p + c_pw'(1);
    endfunction

    // Loader writes land only when the word index is inside the array.
    always_ff @(posedge clk) begin
        if (load_en && (load_addr[31:2] < c_depth_w)) begin
            mem_q[load_addr[c_aw+1:2]] <= load_data;
        end
    end

    // Credits cover pipeline + FIFO, so the FIFO can never overflow.
    assign req_ready = (cnt_q < c_cw'(OUTSTANDING)) && !flush && !load_en;
    assign w_acc     = req_valid && req_ready;

    // Array is read in the accept cycle; later loads cannot change it.
    assign w_rd_err  = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= c_depth_w);
    assign w_rd_data = w_rd_err ? 32'h0 : mem_q[req_addr[c_aw+1:2]];

    // The FIFO write is the last latency stage, so LATENCY-1 registers precede it.
    generate
        if (LATENCY == 1) begin : g_no_pipe
            assign w_push_v    = w_acc;
            assign w_push_addr = req_addr;
            assign w_push_data = w_rd_data;
            assign w_push_err  = w_rd_err;
        end else begin : g_pipe
            logic        pv_q [LATENCY-1];
            logic [31:0] pa_q [LATENCY-1];
            logic [31:0] pd_q [LATENCY-1];
            logic        pe_q [LATENCY-1];

            // Shift captured fetches toward the FIFO; flush kills every stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        pv_q[i] <= 1'b0;
                        pa_q[i] <= '0;
                        pd_q[i] <= '0;
                        pe_q[i] <= 1'b0;
                    end
                end else begin
                    pv_q[0] <= w_acc && !flush;
                    pa_q[0] <= req_addr;
                    pd_q[0] <= w_rd_data;
                    pe_q[0] <= w_rd_err;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        pv_q[i] <= pv_q[i-1] && !flush;
                        pa_q[i] <= pa_q[i-1];
                        pd_q[i] <= pd_q[i-1];
                        pe_q[i] <= pe_q[i-1];
                    end
                end
            end

            assign w_push_v    = pv_q[LATENCY-2];
            assign w_push_addr = pa_q[LATENCY-2];
            assign w_push_data = pd_q[LATENCY-2];
            assign w_push_err  = pe_q[LATENCY-2];
        end
    endgenerate

    assign resp_valid = (fcnt_q != '0);
    assign w_push     = w_push_v && !flush;
    assign w_pop      = resp_valid && resp_ready && !flush;

    // Response FIFO storage; contents are masked at the outputs when empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fa_q[wr_ptr_q] <= w_push_addr;
            fd_q[wr_ptr_q] <= w_push_data;
            fe_q[wr_ptr_q] <= w_push_err;
        end
    end

    // Next-state for FIFO pointers and occupancy / outstanding counters.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fcnt_d   = '0;
            cnt_d    = '0;
        end else begin
            if (w_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (w_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (w_push && !w_pop)      fcnt_d = fcnt_q + c_cw'(1);
            else if (!w_push && w_pop) fcnt_d = fcnt_q - c_cw'(1);
            if (w_acc && !w_pop)       cnt_d  = cnt_q + c_cw'(1);
            else if (!w_acc && w_pop)  cnt_d  = cnt_q - c_cw'(1);
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
            cnt_q    <= cnt_d;
        end
    end

    assign resp_addr = resp_valid ? fa_q[rd_ptr_q] : 32'h0;
    assign resp_inst = resp_valid ? fd_q[rd_ptr_q] : 32'h0;
    assign resp_err  = resp_valid ? fe_q[rd_ptr_q] : 1'b0;
    assign busy      = (cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_server.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_mem_server
// Purpose  : Directed self-checking bench for inst_mem_server (defaults:
//            DEPTH=64, LATENCY=2, OUTSTANDING=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_mem_server;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_addr;
    logic [31:0] resp_inst;
    logic        resp_err;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    inst_mem_server dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_addr  (resp_addr),
        .resp_inst  (resp_inst),
        .resp_err   (resp_err),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_addr  = 32'h0;
        flush     = 1'b0;
        load_en   = 1'b0;
        load_addr = 32'h0;
        load_data = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        resp_ready = 1'b0;
        idle_inputs();
        #2;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b exp 0", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b exp 1", req_ready); end
        checks++; if (resp_addr !== 32'h0 || resp_inst !== 32'h0 || resp_err !== 1'b0) begin
            errors++; $display("FAIL reset_resp_fields: got addr=%h inst=%h err=%b exp 0/0/0", resp_addr, resp_inst, resp_err);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_in_order();
        logic [31:0] exp_inst [4];
        exp_inst[0] = 32'h11; exp_inst[1] = 32'h22; exp_inst[2] = 32'h33; exp_inst[3] = 32'h44;
        for (int i = 0; i < 4; i++) begin
            load_en = 1'b1; load_addr = 32'(i * 4); load_data = exp_inst[i];
            tick();
        end
        load_en = 1'b0;
        resp_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            req_valid = (c < 4);
            req_addr  = 32'(c * 4);
            #1;
            if (c < 4) begin
                checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL inorder_ready c%0d: got %b exp 1", c, req_ready); end
            end
            checks++;
            if (resp_valid !== (c >= 2 && c <= 5)) begin
                errors++; $display("FAIL inorder_valid c%0d: got %b exp %b", c, resp_valid, (c >= 2 && c <= 5));
            end else if (c >= 2 && c <= 5) begin
                if (resp_addr !== 32'((c - 2) * 4) || resp_inst !== exp_inst[c-2] || resp_err !== 1'b0) begin
                    errors++; $display("FAIL inorder_resp c%0d: got addr=%h inst=%h err=%b exp addr=%h inst=%h err=0",
                                       c, resp_addr, resp_inst, resp_err, 32'((c - 2) * 4), exp_inst[c-2]);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        logic [31:0] na;
        logic [31:0] exp_drain [3];
        int n;
        exp_drain[0] = 32'h8; exp_drain[1] = 32'hC; exp_drain[2] = 32'h10;
        na = 32'h0;
        resp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            req_valid = 1'b1; req_addr = na;
            #1;
            checks++; if (req_ready !== (c < 4)) begin errors++; $display("FAIL bp_ready c%0d: got %b exp %b", c, req_ready, (c < 4)); end
            if (req_ready) na = na + 32'd4;
            if (c == 7) begin
                checks++; if (resp_valid !== 1'b1 || resp_addr !== 32'h0 || resp_inst !== 32'h11) begin
                    errors++; $display("FAIL bp_head_hold: got v=%b addr=%h inst=%h exp 1/0/11", resp_valid, resp_addr, resp_inst);
                end
            end
            tick();
        end
        resp_ready = 1'b1; req_addr = na;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b exp 0", req_ready); end
        tick();
        #1;
        checks++; if (req_ready !== 1'b1 || resp_addr !== 32'h4) begin
            errors++; $display("FAIL bp_after_pop: got ready=%b addr=%h exp 1/4", req_ready, resp_addr);
        end
        tick();
        req_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (resp_valid) begin
                checks++;
                if (n > 2 || resp_addr !== exp_drain[(n > 2) ? 2 : n]) begin
                    errors++; $display("FAIL bp_drain_order n%0d: got addr=%h exp %h", n, resp_addr, exp_drain[(n > 2) ? 2 : n]);
                end
                n++;
            end
            tick();
        end
        checks++; if (n != 3 || busy !== 1'b0) begin errors++; $display("FAIL bp_drain_count: got n=%0d busy=%b exp 3/0", n, busy); end
        idle_inputs();
    endtask

    task automatic test_errors();
        logic [31:0] ea [2];
        ea[0] = 32'h2; ea[1] = 32'h100;
        resp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            req_valid = (c < 2);
            req_addr  = ea[(c < 2) ? c : 0];
            #1;
            if (c >= 2 && c <= 3) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_addr !== ea[c-2] || resp_inst !== 32'h0 || resp_err !== 1'b1) begin
                    errors++; $display("FAIL err_resp c%0d: got v=%b addr=%h inst=%h err=%b exp 1/%h/0/1",
                                       c, resp_valid, resp_addr, resp_inst, resp_err, ea[c-2]);
                end
            end
            if (c == 4) begin
                checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL err_empty: got %b exp 0", resp_valid); end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        int seen;
        resp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            req_valid = 1'b1; req_addr = 32'(c * 4);
            tick();
        end
        req_addr = 32'hC; flush = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b1) begin
            errors++; $display("FAIL flush_cycle: got ready=%b v=%b exp 0/1", req_ready, resp_valid);
        end
        tick();
        flush = 1'b0; req_valid = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL flush_after: got v=%b busy=%b ready=%b exp 0/0/1", resp_valid, busy, req_ready);
        end
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (resp_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_resp: got %0d responses exp 0", seen); end
        resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h8;
        tick();
        req_valid = 1'b0;
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_addr !== 32'h8 || resp_inst !== 32'h33) begin
            errors++; $display("FAIL flush_refetch: got v=%b addr=%h inst=%h exp 1/8/33", resp_valid, resp_addr, resp_inst);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_load_inflight();
        resp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h4;
        tick();
        req_valid = 1'b0; load_en = 1'b1; load_addr = 32'h4; load_data = 32'hAA;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL load_blocks_ready: got %b exp 0", req_ready); end
        tick();
        load_en = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_inst !== 32'h22) begin
            errors++; $display("FAIL load_inflight: got v=%b inst=%h exp 1/22", resp_valid, resp_inst);
        end
        tick();
        // Out-of-range load whose low index bits alias word 1 must be dropped.
        load_en = 1'b1; load_addr = 32'h104; load_data = 32'hDEADBEEF;
        tick();
        load_en = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_inst !== 32'hAA || resp_err !== 1'b0) begin
            errors++; $display("FAIL load_new_data: got v=%b inst=%h err=%b exp 1/aa/0", resp_valid, resp_inst, resp_err);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        int seen;
        resp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rst_pre: got v=%b busy=%b exp 1/1", resp_valid, busy);
        end
        rst = 1'b1;
        #1;
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_immediate: got v=%b busy=%b ready=%b exp 0/0/1", resp_valid, busy, req_ready);
        end
        tick(); tick();
        rst = 1'b0;
        resp_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (resp_valid || busy) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_stale: got %0d active cycles exp 0", seen); end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        resp_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_in_order();
        test_backpressure();
        test_errors();
        test_flush();
        test_load_inflight();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
